// File: rtl/multi_cycle_add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding and
// elaboration-time parameter checks.
package add_sub_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // Chunk counter width, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`ifndef ADD_SUB_CHECK_DIV
`define ADD_SUB_CHECK_DIV(w, c) \
  if (((c) == 0) || (((w) % (c)) != 0) || ((c) > (w))) begin : g_bad_chunk \
    $error("multi_cycle_add_sub: WIDTH must be a non-zero multiple of CHUNK"); \
  end
`endif

// File: rtl/multi_cycle_add_sub_chunk_adder.sv
// Combinational W-bit ripple-carry slice; c_msb is the carry into the top bit
// so the caller can derive signed overflow on the final chunk.
module chunk_adder #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic c;

  always_comb begin
    s     = '0;
    c     = ci;
    c_msb = ci;
    for (int i = 0; i < int'(W); i++) begin
      if (i == int'(W) - 1) c_msb = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/multi_cycle_add_sub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice is reused over
// WIDTH/CHUNK cycles, LSB chunk first, with valid/ready on both sides.
module multi_cycle_add_sub
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  `ADD_SUB_CHECK_DIV(WIDTH, CHUNK)

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [CHUNK-1:0]   slice_s;
  logic               slice_co;
  logic               slice_cmsb;

  // Operands shift right each RUN cycle, so the slice always sees the low chunk
  chunk_adder #(.W(CHUNK)) u_slice (
    .x     (a_q[CHUNK-1:0]),
    .y     (b_q[CHUNK-1:0]),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = subtract ? ~b : b;
          carry_d = subtract ? ~cin : cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        // Result chunks enter at the top; after NCHUNK shifts chunk k sits at k*CHUNK
        sum_d   = (sum_q >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));
        carry_d = slice_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CHUNK) begin
          cout_d  = slice_co;
          ovf_d   = slice_cmsb ^ slice_co;
          zero_d  = (sum_d == '0);
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_multi_cycle_add_sub.sv
// Bench for multi_cycle_add_sub: three configurations (8/2, 16/4, 8/8) checked
// against an arithmetic reference model plus hand-computed directed vectors.
module tb_multi_cycle_add_sub;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv   [NI];
  logic        irv  [NI];
  logic [15:0] av   [NI];
  logic [15:0] bv   [NI];
  logic        cinv [NI];
  logic        subv [NI];
  logic        ovv  [NI];
  logic        orv  [NI];
  logic [15:0] sumv [NI];
  logic        coutv[NI];
  logic        ovfv [NI];
  logic        zv   [NI];

  logic [7:0]  sum0, sum2;
  logic [15:0] sum1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  multi_cycle_add_sub #(.WIDTH(8), .CHUNK(2)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irv[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]), .cin(cinv[0]), .subtract(subv[0]),
    .out_valid(ovv[0]), .out_ready(orv[0]), .sum(sum0), .cout(coutv[0]),
    .overflow(ovfv[0]), .zero(zv[0])
  );

  multi_cycle_add_sub #(.WIDTH(16), .CHUNK(4)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irv[1]),
    .a(av[1]), .b(bv[1]), .cin(cinv[1]), .subtract(subv[1]),
    .out_valid(ovv[1]), .out_ready(orv[1]), .sum(sum1), .cout(coutv[1]),
    .overflow(ovfv[1]), .zero(zv[1])
  );

  multi_cycle_add_sub #(.WIDTH(8), .CHUNK(8)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irv[2]),
    .a(av[2][7:0]), .b(bv[2][7:0]), .cin(cinv[2]), .subtract(subv[2]),
    .out_valid(ovv[2]), .out_ready(orv[2]), .sum(sum2), .cout(coutv[2]),
    .overflow(ovfv[2]), .zero(zv[2])
  );

  assign sumv[0] = {8'h00, sum0};
  assign sumv[1] = sum1;
  assign sumv[2] = {8'h00, sum2};

  function automatic int wid(input int i);
    return (i == 1) ? 16 : 8;
  endfunction

  function automatic int nch(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  // Reference result from plain integer arithmetic: {zero, ovf, cout, sum[15:0]}
  function automatic logic [18:0] calc(input int w, input logic [15:0] a,
                                       input logic [15:0] b, input logic cin,
                                       input logic sub);
    longint m, half, ua, ub, t, sa, sb, r, ci;
    logic [15:0] s;
    logic c, v, z;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    ci   = cin ? 1 : 0;
    if (sub) begin
      t = ua - ub - ci;
      c = (ua >= ub + ci);
    end else begin
      t = ua + ub + ci;
      c = ((t >> w) & 1) != 0;
    end
    s  = 16'(t & m);
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    r  = sub ? (sa - sb - ci) : (sa + sb + ci);
    v  = (r >= half) || (r < -half);
    z  = (s == 16'h0000);
    return {z, v, c, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: 0 idle, 1 computing (cycles left in m_cnt), 2 result held
  int          m_mode[NI];
  int          m_cnt [NI];
  logic [18:0] m_pend[NI];
  logic [18:0] m_res [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_mode[i] <= 0;
        m_cnt[i]  <= 0;
        m_res[i]  <= '0;
      end else begin
        case (m_mode[i])
          0: if (iv[i]) begin
               m_pend[i] <= calc(wid(i), av[i], bv[i], cinv[i], subv[i]);
               m_cnt[i]  <= nch(i);
               m_mode[i] <= 1;
             end
          1: begin
               if (m_cnt[i] == 1) begin
                 m_mode[i] <= 2;
                 m_res[i]  <= m_pend[i];
               end
               m_cnt[i] <= m_cnt[i] - 1;
             end
          2: if (orv[i]) m_mode[i] <= 0;
          default: m_mode[i] <= 0;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("cmp%0d_in_ready", i), 32'(irv[i]), 32'(m_mode[i] == 0));
        check($sformatf("cmp%0d_out_valid", i), 32'(ovv[i]), 32'(m_mode[i] == 2));
        if (m_mode[i] == 2) begin
          check($sformatf("cmp%0d_sum", i), 32'(sumv[i]), 32'(m_res[i][15:0]));
          check($sformatf("cmp%0d_cout", i), 32'(coutv[i]), 32'(m_res[i][16]));
          check($sformatf("cmp%0d_ovf", i), 32'(ovfv[i]), 32'(m_res[i][17]));
          check($sformatf("cmp%0d_zero", i), 32'(zv[i]), 32'(m_res[i][18]));
        end
      end
    end
  end

  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input string tag);
    int k;
    @(negedge clk);
    k = 0;
    while (!irv[i] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready_wait"}, 32'(irv[i]), 32'd1);
    av[i] = a; bv[i] = b; cinv[i] = cin; subv[i] = sub; iv[i] = 1'b1;
    @(posedge clk);
    #1 iv[i] = 1'b0;
  endtask

  task automatic wait_check(input int i, input string tag, input logic [15:0] s,
                            input logic c, input logic v, input logic z, input int lat_exp);
    int lat;
    lat = 0;
    while (!ovv[i] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    check({tag, "_sum"}, 32'(sumv[i]), 32'(s));
    check({tag, "_cout"}, 32'(coutv[i]), 32'(c));
    check({tag, "_ovf"}, 32'(ovfv[i]), 32'(v));
    check({tag, "_zero"}, 32'(zv[i]), 32'(z));
  endtask

  typedef struct {
    int          i;
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        c, v, z;
  } vec_t;

  vec_t tab[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; av[i] = '0; bv[i] = '0; cinv[i] = 1'b0; subv[i] = 1'b0; orv[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst%0d_in_ready", i), 32'(irv[i]), 32'd1);
      check($sformatf("rst%0d_out_valid", i), 32'(ovv[i]), 32'd0);
      check($sformatf("rst%0d_sum", i), 32'(sumv[i]), 32'd0);
      check($sformatf("rst%0d_flags", i), 32'({coutv[i], ovfv[i], zv[i]}), 32'd0);
    end
    chk_en = 1'b1;

    // Hand-computed vectors; 8-bit set runs on both the 8/2 and 8/8 instances
    for (int k = 0; k < 3; k += 2) begin
      tab.push_back('{k, 16'h00AA, 16'h0055, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0});
      tab.push_back('{k, 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1, 1'b0});
      tab.push_back('{k, 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0});
      tab.push_back('{k, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1});
      tab.push_back('{k, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0});
      tab.push_back('{k, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0});
    end
    tab.push_back('{1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0});
    tab.push_back('{1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1});
    tab.push_back('{1, 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1});
    tab.push_back('{1, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b1, 1'b1, 1'b0});

    foreach (tab[n]) begin
      issue(tab[n].i, tab[n].a, tab[n].b, tab[n].cin, tab[n].sub, $sformatf("vec%0d", n));
      wait_check(tab[n].i, $sformatf("vec%0d", n), tab[n].s, tab[n].c, tab[n].v, tab[n].z,
                 nch(tab[n].i));
    end

    // Backpressure: result must hold while inputs churn
    orv[0] = 1'b0;
    issue(0, 16'h0012, 16'h0034, 1'b0, 1'b0, "bp");
    wait_check(0, "bp", 16'h0046, 1'b0, 1'b0, 1'b0, 4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      av[0] = 16'($urandom); bv[0] = 16'($urandom); iv[0] = ~iv[0];
      @(posedge clk);
      #1;
      check("bp_hold_in_ready", 32'(irv[0]), 32'd0);
      check("bp_hold_valid", 32'(ovv[0]), 32'd1);
      check("bp_hold_sum", 32'(sumv[0]), 32'h46);
    end
    @(negedge clk);
    av[0] = 16'h0001; bv[0] = 16'h0002; cinv[0] = 1'b0; subv[0] = 1'b0; iv[0] = 1'b1;
    orv[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_xfer_in_ready", 32'(irv[0]), 32'd1);
    check("bp_xfer_valid", 32'(ovv[0]), 32'd0);
    @(posedge clk);
    #1 iv[0] = 1'b0;
    check("bp_accept_in_ready", 32'(irv[0]), 32'd0);
    wait_check(0, "bp_next", 16'h0003, 1'b0, 1'b0, 1'b0, 4);

    // Reset during the second RUN cycle discards the operation
    issue(0, 16'h00FF, 16'h00FF, 1'b0, 1'b0, "mid_rst");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("mid_rst_in_ready", 32'(irv[0]), 32'd1);
    check("mid_rst_out_valid", 32'(ovv[0]), 32'd0);
    check("mid_rst_sum", 32'(sumv[0]), 32'd0);
    check("mid_rst_flags", 32'({coutv[0], ovfv[0], zv[0]}), 32'd0);
    issue(0, 16'h0001, 16'h0001, 1'b0, 1'b0, "post_rst");
    wait_check(0, "post_rst", 16'h0002, 1'b0, 1'b0, 1'b0, 4);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_add_sub.md
# multi_cycle_add_sub

Parametrised, multi-cycle adder/subtractor. It processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first, through a single narrow carry-chain slice, trading latency for area. It sits between an operand source and a result consumer, with a valid/ready handshake on both sides. It returns sum, carry-out, signed overflow and zero flags.

## Interface
- WIDTH, 8, operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 2, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept a new operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (subtract).
- subtract  in  1  0: a+b+cin; 1: a−b−cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out; when subtracting, 1 means no borrow.
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

## Operation
- NCHUNK = WIDTH/CHUNK.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch a and b_eff = subtract ? ~b : b.
  - Latch carry = subtract ? ~cin : cin.
  - Clear chunk counter to 0; go to RUN.
- RUN:
  - Each cycle, add chunk k of a, chunk k of b_eff and carry.
  - Write the CHUNK result bits into sum[k*CHUNK +: CHUNK]; register the new carry.
  - Increment k.
  - After chunk NCHUNK−1, register cout = final carry.
  - Register overflow = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - Register zero = (full sum == 0); go to DONE.
- DONE:
  - out_valid=1; sum and flags held stable.
  - On out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE; a, b, cin, subtract and in_valid are ignored there.
- Subtract identity: a + ~b + ~cin = a − b − cin (mod 2^WIDTH).
- Reset, from any state including mid-RUN:
  - Next state IDLE; the operation in flight is discarded.
  - Reset values: in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, zero=0, counter=0.
- sum and flags change only during RUN and at reset. They are undefined to the consumer outside out_valid, but in practice hold their last values.

## Timing
- Accept edge = edge where in_valid && in_ready.
- out_valid rises exactly NCHUNK cycles after the accept edge (CHUNK=WIDTH gives latency 1).
- Result transfer: edge where out_valid && out_ready.
- in_ready rises the cycle after the transfer edge.
- Minimum issue interval is NCHUNK+2 cycles; there is no overlap of operations.
- out_ready held high before out_valid rises: transfer on the first DONE cycle.
- out_ready low in DONE: hold indefinitely, with outputs bit-stable.
- in_valid and out_ready may both be high in the same cycle without interaction, because the block is never in IDLE and DONE together.

## Structure
- Shared package add_sub_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Compile-time check macro for WIDTH % CHUNK == 0.
- Sub-module chunk_adder (#(W=CHUNK)):
  - Combinational W-bit ripple slice.
  - Inputs: x, y, ci. Outputs: s, co, and c_msb (carry into the top bit), used for overflow on the last chunk.
- Top-level RTL contains the FSM, chunk counter ($clog2(NCHUNK), minimum 1 bit), operand/result registers and flag logic.

## Test plan
- WIDTH=8, CHUNK=2, add 0xAA+0x55, cin=0:
  - sum=0xFF, cout=0, overflow=0, zero=0.
  - out_valid exactly 4 cycles after accept.
- Subtract 0x80−0x01, cin=0:
  - sum=0x7F, cout=1, overflow=1, zero=0.
- Subtract 0x05−0x05, cin=1:
  - sum=0xFF, cout=0, zero=0.
- Add 0xFF+0x01, cin=0:
  - sum=0x00, cout=1, overflow=0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling a, b and in_valid.
  - sum and flags stay stable; in_ready=0; a new operation is accepted only after transfer.
- Reset asserted on the 2nd RUN cycle:
  - Next cycle in IDLE, in_ready=1, out_valid=0, sum=0, flags=0.
  - A following 0x01+0x01 gives sum=0x02.
- WIDTH=16, CHUNK=4, add 0x7FFF+0x0001:
  - sum=0x8000, overflow=1, cout=0, latency 4.
- WIDTH=CHUNK=8:
  - Latency 1 for the same vectors as above.
